// File: rtl/sv32_ptw_ctrl.sv
// Sv32 page-table-walk sequencer.
// Two-level PTE walk, permission check, A/D write-back.
module sv32_ptw_ctrl #(
  parameter int PA_W = 34,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [1:0]      req_type,
  input  logic [XLEN-1:0] req_vaddr,
  output logic            req_ready,
  input  logic [XLEN-1:0] satp,
  input  logic [1:0]      msu,
  input  logic            mxr,
  input  logic            sum,
  output logic            bus_req,
  output logic            bus_write,
  output logic [PA_W-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic            bus_err,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            done,
  output logic [PA_W-1:0] paddr,
  output logic            fault,
  output logic [3:0]      fault_cause
);

  typedef enum logic [2:0] {
    S_IDLE, S_L1_RD, S_L1_CHK, S_L0_RD,
    S_L0_CHK, S_AD_WR, S_DONE
  } state_t;

  state_t          r_state, w_next;
  logic [XLEN-1:0] r_vaddr, r_pte;
  logic [21:0]     r_root;
  logic            r_fetch, r_store;
  logic [1:0]      r_msu;
  logic            r_mxr, r_sum, r_l1leaf;
  logic [PA_W-1:0] r_ptaddr, r_paddr;
  logic            r_fault;
  logic [3:0]      r_cause;

  logic            w_accept, w_bare, w_rd_ack;
  logic            w_set_res, w_res_fault;
  logic [PA_W-1:0] w_res_paddr, w_l1_addr, w_l0_addr;
  logic [PA_W-1:0] w_leaf_paddr;
  logic [3:0]      w_res_cause, w_pf, w_af;
  logic            w_v, w_r, w_w, w_x, w_u, w_a, w_d;
  logic            w_is_l1, w_perm_ok, w_priv_bad;
  logic            w_need_ad;
  logic            w_unused;

  assign w_unused = ^satp[30:22];

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_bare   = !satp[31] || (msu == 2'b11);
  assign w_rd_ack = bus_ack && !bus_err &&
                    ((r_state == S_L1_RD) ||
                     (r_state == S_L0_RD));

  assign w_l1_addr = {r_root, 12'b0} +
                     {22'b0, r_vaddr[31:22], 2'b0};
  assign w_l0_addr = {r_pte[31:10], 12'b0} +
                     {22'b0, r_vaddr[21:12], 2'b0};

  assign w_v = r_pte[0];
  assign w_r = r_pte[1];
  assign w_w = r_pte[2];
  assign w_x = r_pte[3];
  assign w_u = r_pte[4];
  assign w_a = r_pte[6];
  assign w_d = r_pte[7];

  assign w_is_l1 = (r_state == S_L1_CHK) ||
                   ((r_state == S_AD_WR) && r_l1leaf);

  assign w_perm_ok = r_fetch ? w_x :
                     r_store ? w_w :
                     (w_r || (w_x && r_mxr));
  assign w_priv_bad =
    (w_u && (r_msu == 2'b01) && (r_fetch || !r_sum)) ||
    (!w_u && (r_msu == 2'b00));
  assign w_need_ad = !w_a || (r_store && !w_d);

  assign w_leaf_paddr = w_is_l1 ?
    {r_pte[31:20], r_vaddr[21:0]} :
    {r_pte[31:10], r_vaddr[11:0]};

  assign w_pf = r_fetch ? 4'd12 : r_store ? 4'd15 : 4'd13;
  assign w_af = r_fetch ? 4'd1  : r_store ? 4'd7  : 4'd5;

  // next state and result to capture on entry to DONE
  always_comb begin
    w_next      = r_state;
    w_set_res   = 1'b0;
    w_res_fault = 1'b0;
    w_res_cause = 4'd0;
    w_res_paddr = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_bare) begin
            w_next      = S_DONE;
            w_set_res   = 1'b1;
            w_res_paddr = {2'b0, req_vaddr};
          end else begin
            w_next = S_L1_RD;
          end
        end
      end
      S_L1_RD, S_L0_RD, S_AD_WR: begin
        if (bus_ack) begin
          if (bus_err) begin
            w_next      = S_DONE;
            w_set_res   = 1'b1;
            w_res_fault = 1'b1;
            w_res_cause = w_af;
          end else if (r_state == S_L1_RD) begin
            w_next = S_L1_CHK;
          end else if (r_state == S_L0_RD) begin
            w_next = S_L0_CHK;
          end else begin
            w_next      = S_DONE;
            w_set_res   = 1'b1;
            w_res_paddr = w_leaf_paddr;
          end
        end
      end
      S_L1_CHK, S_L0_CHK: begin
        w_next      = S_DONE;
        w_set_res   = 1'b1;
        w_res_fault = 1'b1;
        w_res_cause = w_pf;
        if (!w_v || (!w_r && w_w)) begin
          w_next = S_DONE;
        end else if (!(w_r || w_w || w_x)) begin
          if (w_is_l1) begin
            w_next      = S_L0_RD;
            w_set_res   = 1'b0;
            w_res_fault = 1'b0;
            w_res_cause = 4'd0;
          end
        end else if (w_is_l1 &&
                     (r_pte[19:10] != 10'd0)) begin
          w_next = S_DONE;
        end else if (!w_perm_ok || w_priv_bad) begin
          w_next = S_DONE;
        end else if (w_need_ad) begin
          w_next      = S_AD_WR;
          w_set_res   = 1'b0;
          w_res_fault = 1'b0;
          w_res_cause = 4'd0;
        end else begin
          w_res_fault = 1'b0;
          w_res_cause = 4'd0;
          w_res_paddr = w_leaf_paddr;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // state, latched request context, PTE and result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_vaddr  <= '0;
      r_pte    <= '0;
      r_root   <= '0;
      r_fetch  <= 1'b0;
      r_store  <= 1'b0;
      r_msu    <= 2'b00;
      r_mxr    <= 1'b0;
      r_sum    <= 1'b0;
      r_l1leaf <= 1'b0;
      r_ptaddr <= '0;
      r_paddr  <= '0;
      r_fault  <= 1'b0;
      r_cause  <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_vaddr <= req_vaddr;
        r_root  <= satp[21:0];
        r_fetch <= (req_type == 2'b00);
        r_store <= (req_type == 2'b10);
        r_msu   <= msu;
        r_mxr   <= mxr;
        r_sum   <= sum;
      end
      if (w_rd_ack) begin
        r_pte    <= bus_rdata;
        r_ptaddr <= bus_addr;
      end
      if (r_state == S_L1_CHK) begin
        r_l1leaf <= 1'b1;
      end else if (r_state == S_L0_CHK) begin
        r_l1leaf <= 1'b0;
      end
      if (w_set_res) begin
        r_paddr <= w_res_paddr;
        r_fault <= w_res_fault;
        r_cause <= w_res_cause;
      end
    end
  end

  // bus drive decoded from state so reset drops it at once
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    unique case (1'b1)
      (r_state == S_L1_RD): bus_addr = w_l1_addr;
      (r_state == S_L0_RD): bus_addr = w_l0_addr;
      (r_state == S_AD_WR): begin
        bus_addr  = r_ptaddr;
        bus_wdata = r_pte | 32'h40 |
                    (r_store ? 32'h80 : 32'h0);
      end
      default: bus_addr = '0;
    endcase
  end

  assign req_ready   = (r_state == S_IDLE);
  assign bus_req     = (r_state == S_L1_RD) ||
                       (r_state == S_L0_RD) ||
                       (r_state == S_AD_WR);
  assign bus_write   = (r_state == S_AD_WR);
  assign done        = (r_state == S_DONE);
  assign paddr       = r_paddr;
  assign fault       = r_fault;
  assign fault_cause = r_cause;

endmodule

// File: tb/tb_sv32_ptw_ctrl.sv
// Bench for sv32_ptw_ctrl: directed cases plus
// random walks against a behavioural walk model.
module tb_sv32_ptw_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_type = 2'b00;
  logic [31:0] req_vaddr = '0;
  logic        req_ready;
  logic [31:0] satp = '0;
  logic [1:0]  msu = 2'b00;
  logic        mxr = 1'b0;
  logic        sum = 1'b0;
  logic        bus_req, bus_write;
  logic [33:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        done, fault;
  logic [33:0] paddr;
  logic [3:0]  fault_cause;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mem [logic [33:0]];
  int waits [3];
  int err_at;

  logic [33:0] e_addr [$];
  logic        e_wr [$];
  logic [31:0] e_wd [$];
  logic        e_fault;
  logic [3:0]  e_cause;
  logic [33:0] e_paddr;
  int          e_lat;

  logic [33:0] o_addr [$];
  logic [31:0] o_wd [$];
  logic        o_done, o_fault;
  logic [3:0]  o_cause;
  logic [33:0] o_paddr;
  int          o_lat;

  always #5 clk = ~clk;

  sv32_ptw_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_type(req_type),
    .req_vaddr(req_vaddr), .req_ready(req_ready),
    .satp(satp), .msu(msu), .mxr(mxr), .sum(sum),
    .bus_req(bus_req), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err),
    .bus_rdata(bus_rdata),
    .done(done), .paddr(paddr), .fault(fault),
    .fault_cause(fault_cause)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
  endtask

  function automatic logic [31:0] rd(input logic [33:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // walk model: expected accesses, result and latency
  task automatic model(input logic [1:0] ty,
                       input logic [31:0] va,
                       input logic [31:0] st,
                       input logic [1:0] pm,
                       input logic mx, input logic su);
    logic fetch, store, perm;
    logic [3:0] pf, af;
    logic [33:0] a;
    logic [31:0] pte;
    int lvl, k;
    fetch = (ty == 2'd0);
    store = (ty == 2'd2);
    pf = fetch ? 4'd12 : store ? 4'd15 : 4'd13;
    af = fetch ? 4'd1 : store ? 4'd7 : 4'd5;
    e_addr.delete(); e_wr.delete(); e_wd.delete();
    e_fault = 1'b0; e_cause = 4'd0; e_paddr = '0;
    e_lat = 1;
    if (!st[31] || pm == 2'd3) begin
      e_paddr = {2'b0, va};
      return;
    end
    a = 34'(st[21:0]) * 34'd4096 + 34'(va[31:22]) * 34'd4;
    lvl = 1;
    forever begin
      k = e_addr.size();
      e_addr.push_back(a); e_wr.push_back(1'b0);
      e_wd.push_back(32'h0);
      e_lat += waits[k] + 1;
      if (err_at == k + 1) begin
        e_fault = 1'b1; e_cause = af; return;
      end
      pte = rd(a);
      e_lat += 1;
      if (!pte[0] || (!pte[1] && pte[2])) begin
        e_fault = 1'b1; e_cause = pf; return;
      end
      if (pte[3:1] == 3'b000) begin
        if (lvl == 0) begin
          e_fault = 1'b1; e_cause = pf; return;
        end
        a = 34'(pte[31:10]) * 34'd4096 +
            34'(va[21:12]) * 34'd4;
        lvl = 0;
        continue;
      end
      perm = fetch ? pte[3] : store ? pte[2] :
             (pte[1] || (pte[3] && mx));
      if ((lvl == 1 && pte[19:10] != 10'd0) || !perm ||
          (pte[4] && pm == 2'd1 && (fetch || !su)) ||
          (!pte[4] && pm == 2'd0)) begin
        e_fault = 1'b1; e_cause = pf; return;
      end
      if (!pte[6] || (store && !pte[7])) begin
        k = e_addr.size();
        e_addr.push_back(a); e_wr.push_back(1'b1);
        e_wd.push_back(pte | 32'h40 |
                       (store ? 32'h80 : 32'h0));
        e_lat += waits[k] + 1;
        if (err_at == k + 1) begin
          e_fault = 1'b1; e_cause = af; return;
        end
      end
      if (lvl == 1) e_paddr = {pte[31:20], va[21:0]};
      else          e_paddr = {pte[31:10], va[11:0]};
      return;
    end
  endtask

  task automatic run(input logic [1:0] ty,
                     input logic [31:0] va,
                     input logic [31:0] st,
                     input logic [1:0] pm,
                     input logic mx, input logic su,
                     input bit stray);
    int cyc, w, acc, wt;
    bit held;
    model(ty, va, st, pm, mx, su);
    o_addr.delete(); o_wd.delete();
    o_done = 1'b0; o_fault = 1'b0; o_cause = 4'd0;
    o_paddr = '0; o_lat = 0;
    @(negedge clk);
    check("ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_type = ty; req_vaddr = va;
    satp = st; msu = pm; mxr = mx; sum = su;
    @(negedge clk);
    req_valid = 1'b0;
    req_type = 2'($urandom); req_vaddr = $urandom;
    satp = $urandom; msu = 2'($urandom);
    mxr = 1'($urandom); sum = 1'($urandom);
    cyc = 1; acc = 0; w = 0; held = 0;
    while (cyc < 60) begin
      if (done) begin
        o_done = 1'b1; o_lat = cyc; o_fault = fault;
        o_cause = fault_cause; o_paddr = paddr;
        break;
      end
      bus_ack = 1'b0; bus_err = 1'b0;
      bus_rdata = $urandom;
      if (bus_req) begin
        if (!held) begin
          held = 1; w = 0;
          o_addr.push_back(bus_addr);
          o_wd.push_back(bus_wdata);
        end
        if (acc < e_addr.size()) begin
          check("bus_addr", 64'(bus_addr),
                64'(e_addr[acc]));
          check("bus_write", 64'(bus_write),
                64'(e_wr[acc]));
          if (e_wr[acc])
            check("bus_wdata", 64'(bus_wdata),
                  64'(e_wd[acc]));
        end
        wt = (acc < 3) ? waits[acc] : 0;
        if (w >= wt) begin
          bus_ack = 1'b1;
          bus_err = (err_at == acc + 1);
          bus_rdata = rd(bus_addr);
          acc++; held = 0;
        end else begin
          w++;
        end
      end else if (stray && $urandom_range(0, 3) == 0) begin
        bus_ack = 1'b1; bus_err = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    bus_ack = 1'b0; bus_err = 1'b0;
    check("done_seen", 64'(o_done), 64'd1);
    if (o_done) begin
      check("fault", 64'(o_fault), 64'(e_fault));
      if (e_fault)
        check("cause", 64'(o_cause), 64'(e_cause));
      else
        check("paddr", 64'(o_paddr), 64'(e_paddr));
      check("latency", 64'(o_lat), 64'(e_lat));
      check("n_acc", 64'(o_addr.size()),
            64'(e_addr.size()));
      @(negedge clk);
      check("done_pulse", 64'(done), 64'd0);
    end
  endtask

  function automatic logic [31:0] gen_pte(input bit l1);
    logic [31:0] p;
    p = $urandom;
    p[0] = ($urandom_range(0, 7) != 0);
    if (l1 && $urandom_range(0, 1) == 1) p[3:1] = 3'b000;
    else if ($urandom_range(0, 2) != 0) p[1] = 1'b1;
    if (l1 && $urandom_range(0, 2) != 0) p[19:10] = 10'd0;
    if ($urandom_range(0, 2) != 0) p[6] = 1'b1;
    if ($urandom_range(0, 1) == 1) p[7] = 1'b1;
    return p;
  endfunction

  task automatic setup_4k(input logic [31:0] l0);
    mem.delete();
    mem[34'h1_0004] = 32'h0000_8001;
    mem[34'h2_0004] = l0;
    waits = '{0, 0, 0};
    err_at = 0;
  endtask

  initial begin
    logic [31:0] st, va, p1;
    logic [33:0] a1, a0;
    logic [1:0]  pm;
    int          k;

    repeat (2) @(negedge clk);
    check("rst_bus_req", 64'(bus_req), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_cause", 64'(fault_cause), 64'd0);
    check("rst_addr", 64'(bus_addr), 64'd0);
    check("rst_wdata", 64'(bus_wdata), 64'd0);
    rst = 1'b1;

    setup_4k(32'h000D_14CF);
    run(2'd1, 32'h0040_1234, 32'h8000_0010, 2'd1, 0, 0, 0);
    check("t1_paddr", 64'(o_paddr), 64'h34_5234);
    check("t1_lat", 64'(o_lat), 64'd5);
    check("t1_reads", 64'(o_addr.size()), 64'd2);

    setup_4k(32'h0);
    mem[34'h1_0004] = 32'h0030_00CF;
    run(2'd0, 32'h0040_1234, 32'h8000_0010, 2'd1, 0, 0, 0);
    check("t2_paddr", 64'(o_paddr), 64'hC0_1234);
    check("t2_lat", 64'(o_lat), 64'd3);
    check("t2_reads", 64'(o_addr.size()), 64'd1);
    mem[34'h1_0004] = 32'h0030_04CF;
    run(2'd1, 32'h0040_1234, 32'h8000_0010, 2'd1, 0, 0, 0);
    check("t2_misalign", 64'(o_cause), 64'd13);

    setup_4k(32'h000D_1447);
    run(2'd2, 32'h0040_1234, 32'h8000_0010, 2'd1, 0, 0, 0);
    check("t3_nacc", 64'(o_addr.size()), 64'd3);
    if (o_addr.size() == 3) begin
      check("t3_waddr", 64'(o_addr[2]), 64'h2_0004);
      check("t3_wdata", 64'(o_wd[2]), 64'h000D_14C7);
    end
    check("t3_paddr", 64'(o_paddr), 64'h34_5234);

    setup_4k(32'h000D_14C3);
    run(2'd2, 32'h0040_1234, 32'h8000_0010, 2'd1, 0, 0, 0);
    check("t4_cause", 64'(o_cause), 64'd15);
    check("t4_nowrite", 64'(o_addr.size()), 64'd2);
    setup_4k(32'h000D_14CF);
    run(2'd1, 32'h0040_1234, 32'h8000_0010, 2'd0, 0, 0, 0);
    check("t4_umode", 64'(o_cause), 64'd13);
    setup_4k(32'h000D_14DF);
    run(2'd0, 32'h0040_1234, 32'h8000_0010, 2'd1, 0, 1, 0);
    check("t4_sfetch", 64'(o_cause), 64'd12);
    setup_4k(32'h000D_14C9);
    run(2'd1, 32'h0040_1234, 32'h8000_0010, 2'd1, 1, 0, 0);
    check("t4_mxr_f", 64'(o_fault), 64'd0);
    check("t4_mxr_pa", 64'(o_paddr), 64'h34_5234);

    setup_4k(32'h000D_14CF);
    err_at = 1;
    run(2'd0, 32'h0040_1234, 32'h8000_0010, 2'd1, 0, 0, 0);
    check("t5_berr", 64'(o_cause), 64'd1);

    setup_4k(32'h000D_14CF);
    @(negedge clk);
    req_valid = 1'b1; req_type = 2'd1;
    req_vaddr = 32'h0040_1234; satp = 32'h8000_0010;
    msu = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (k < 10 && !(bus_req && bus_addr == 34'h2_0004))
    begin
      bus_ack = bus_req;
      bus_rdata = rd(bus_addr);
      @(negedge clk);
      k++;
    end
    bus_ack = 1'b0;
    check("t5_in_l0", 64'(k < 10), 64'd1);
    #2 rst = 1'b0;
    #1 check("t5_rst_req", 64'(bus_req), 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_ready", 64'(req_ready), 64'd1);

    mem.delete();
    run(2'd1, 32'hFFFF_F000, 32'h0, 2'd1, 0, 0, 0);
    check("t6_bare_pa", 64'(o_paddr), 64'hFFFF_F000);
    check("t6_bare_lat", 64'(o_lat), 64'd1);
    check("t6_bare_bus", 64'(o_addr.size()), 64'd0);
    run(2'd2, 32'hFFFF_F000, 32'h8000_0010, 2'd3, 0, 0, 0);
    check("t6_m_pa", 64'(o_paddr), 64'hFFFF_F000);
    check("t6_m_lat", 64'(o_lat), 64'd1);

    repeat (300) begin
      mem.delete();
      st = {1'($urandom_range(0, 9) != 0), 9'($urandom),
            22'($urandom)};
      va = $urandom;
      k = $urandom_range(0, 9);
      pm = (k == 0) ? 2'd3 : (k < 5) ? 2'd0 : 2'd1;
      a1 = 34'(st[21:0]) * 34'd4096 +
           34'(va[31:22]) * 34'd4;
      p1 = gen_pte(1);
      mem[a1] = p1;
      if (p1[3:1] == 3'b000) begin
        a0 = 34'(p1[31:10]) * 34'd4096 +
             34'(va[21:12]) * 34'd4;
        mem[a0] = gen_pte(0);
      end
      for (int i = 0; i < 3; i++)
        waits[i] = $urandom_range(0, 2);
      err_at = $urandom_range(0, 8);
      run(2'($urandom), va, st, pm, 1'($urandom),
          1'($urandom), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
